// File: rtl/buffer_de_escrita_if.sv
// Bus bundle for the write-back buffer: producer handshake, register-file
// write port, bypass lookup and occupancy.
interface buffer_de_escrita_if;
  logic        req_valid;
  logic [4:0]  req_address;
  logic [31:0] req_data;
  logic        req_ready;
  logic        port_stall;
  logic [4:0]  address_to_write;
  logic [31:0] data_to_write;
  logic        signal_write;
  logic [4:0]  lookup_address;
  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic [4:0]  count;

  modport master (
    output req_valid, req_address, req_data, port_stall, lookup_address,
    input  req_ready, address_to_write, data_to_write, signal_write,
           lookup_hit, lookup_data, count
  );

  modport slave (
    input  req_valid, req_address, req_data, port_stall, lookup_address,
    output req_ready, address_to_write, data_to_write, signal_write,
           lookup_hit, lookup_data, count
  );
endinterface

// File: rtl/buffer_de_escrita.sv
// Write-back buffer: circular FIFO of pending register writes drained into a
// registered write port, with a combinational newest-first bypass lookup.
module buffer_de_escrita #(
  parameter int DEPTH = 4
) (
  input logic            clock_in,
  input logic            signal_reset,
  buffer_de_escrita_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [4:0]       addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] lk_idx;
  logic [4:0]       count;
  logic             accept;
  logic             push;
  logic             pop;
  logic             write_q;
  logic [4:0]       address_q;
  logic [31:0]      data_q;
  logic             hit;
  logic [31:0]      hit_data;

  assign bus.req_ready = signal_reset && (count < DEPTH_C);
  assign accept        = bus.req_valid && bus.req_ready;
  // Writes to register 0 complete the handshake but never occupy a slot.
  assign push          = accept && (bus.req_address != 5'd0);
  assign pop           = (count != 5'd0) && !bus.port_stall;

  always_ff @(posedge clock_in) begin
    if (push) begin
      addr_mem[wr_ptr] <= bus.req_address;
      data_mem[wr_ptr] <= bus.req_data;
    end
  end

  always_ff @(posedge clock_in) begin
    if (!signal_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= 5'd0;
      write_q   <= 1'b0;
      address_q <= 5'd0;
      data_q    <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      write_q <= pop;
      if (pop) begin
        address_q <= addr_mem[rd_ptr];
        data_q    <= data_mem[rd_ptr];
      end
    end
  end

  // Scan oldest to newest so the newest queued match overrides; the output
  // register only wins when nothing in the queue matches.
  always_comb begin
    hit      = 1'b0;
    hit_data = 32'd0;
    lk_idx   = '0;
    if (signal_reset && (bus.lookup_address != 5'd0)) begin
      if (write_q && (address_q == bus.lookup_address)) begin
        hit      = 1'b1;
        hit_data = data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        lk_idx = rd_ptr + PTR_W'(i);
        if ((5'(i) < count) && (addr_mem[lk_idx] == bus.lookup_address)) begin
          hit      = 1'b1;
          hit_data = data_mem[lk_idx];
        end
      end
    end
  end

  assign bus.lookup_hit       = hit;
  assign bus.lookup_data      = hit_data;
  assign bus.signal_write     = write_q;
  assign bus.address_to_write = address_q;
  assign bus.data_to_write    = data_q;
  assign bus.count            = count;

endmodule

// File: tb/tb_buffer_de_escrita.sv
// Self-checking bench: queue-based model of the write-back buffer compared
// every cycle, plus directed scenarios with literal expectations.
module tb_buffer_de_escrita;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  buffer_de_escrita_if bus ();

  buffer_de_escrita #(.DEPTH(DEPTH)) dut (
    .clock_in    (clk),
    .signal_reset(rst_n),
    .bus         (bus)
  );

  entry_t      m_q[$];
  logic        m_sw;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          tests = 0;
  int          fails = 0;
  logic [4:0]  wr_log[$];

  // Model: pending entries in a queue, output register as three variables.
  task automatic modelStep();
    entry_t e;
    bit     rdy;
    if (!rst_n) begin
      m_q.delete();
      m_sw   = 1'b0;
      m_addr = 5'd0;
      m_data = 32'd0;
    end else begin
      rdy = (m_q.size() < DEPTH);
      if (m_q.size() > 0 && !bus.port_stall) begin
        e      = m_q.pop_front();
        m_sw   = 1'b1;
        m_addr = e.a;
        m_data = e.d;
      end else begin
        m_sw = 1'b0;
      end
      if (bus.req_valid && rdy && bus.req_address != 5'd0)
        m_q.push_back('{a: bus.req_address, d: bus.req_data});
    end
  endtask

  initial begin
    m_sw   = 1'b0;
    m_addr = 5'd0;
    m_data = 32'd0;
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  function automatic void modelLookup(input logic [4:0] la, output logic hit,
                                      output logic [31:0] d);
    hit = 1'b0;
    d   = 32'd0;
    if (rst_n && la != 5'd0) begin
      for (int i = m_q.size() - 1; i >= 0 && !hit; i--) begin
        if (m_q[i].a == la) begin
          hit = 1'b1;
          d   = m_q[i].d;
        end
      end
      if (!hit && m_sw && m_addr == la) begin
        hit = 1'b1;
        d   = m_data;
      end
    end
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic        eh;
    logic [31:0] ed;
    modelLookup(bus.lookup_address, eh, ed);
    cmp("req_ready", 32'(bus.req_ready), 32'(rst_n && (m_q.size() < DEPTH)));
    cmp("count", 32'(bus.count), 32'(m_q.size()));
    cmp("signal_write", 32'(bus.signal_write), 32'(m_sw));
    cmp("address_to_write", 32'(bus.address_to_write), 32'(m_addr));
    cmp("data_to_write", bus.data_to_write, m_data);
    cmp("lookup_hit", 32'(bus.lookup_hit), 32'(eh));
    cmp("lookup_data", bus.lookup_data, ed);
  endtask

  // Drive one cycle's inputs just after the falling edge, then check.
  task automatic applyStimulus(input logic r, input logic v, input logic [4:0] a,
                               input logic [31:0] d, input logic s,
                               input logic [4:0] la);
    @(negedge clk);
    rst_n              = r;
    bus.req_valid      = v;
    bus.req_address    = a;
    bus.req_data       = d;
    bus.port_stall     = s;
    bus.lookup_address = la;
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    logic pend;
    rst_n              = 1'b0;
    bus.req_valid      = 1'b0;
    bus.req_address    = 5'd0;
    bus.req_data       = 32'd0;
    bus.port_stall     = 1'b0;
    bus.lookup_address = 5'd0;

    // Reset state
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h3, 1'b0, 5'd3);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h3, 1'b0, 5'd3);
    cmp("rst_ready", 32'(bus.req_ready), 32'd0);
    cmp("rst_count", 32'(bus.count), 32'd0);
    cmp("rst_write", 32'(bus.signal_write), 32'd0);
    cmp("rst_addr", 32'(bus.address_to_write), 32'd0);
    cmp("rst_hit", 32'(bus.lookup_hit), 32'd0);

    // Single request latency
    applyStimulus(1'b1, 1'b1, 5'd5, 32'h1, 1'b0, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5);
    cmp("lat_count1", 32'(bus.count), 32'd1);
    cmp("lat_write0", 32'(bus.signal_write), 32'd0);
    cmp("lat_hit_q", 32'(bus.lookup_hit), 32'd1);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cmp("lat_write1", 32'(bus.signal_write), 32'd1);
    cmp("lat_addr", 32'(bus.address_to_write), 32'd5);
    cmp("lat_data", bus.data_to_write, 32'h1);
    cmp("lat_count0", 32'(bus.count), 32'd0);
    idle(2);

    // Address zero is discarded
    applyStimulus(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
    cmp("zero_ready", 32'(bus.req_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cmp("zero_count", 32'(bus.count), 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cmp("zero_write", 32'(bus.signal_write), 32'd0);

    // Fill under stall, then drain in order
    for (int k = 1; k <= 4; k++)
      applyStimulus(1'b1, 1'b1, 5'(k), 32'(k * 16), 1'b1, 5'd0);
    applyStimulus(1'b1, 1'b1, 5'd5, 32'h50, 1'b1, 5'd0);
    cmp("full_ready", 32'(bus.req_ready), 32'd0);
    cmp("full_count", 32'(bus.count), 32'd4);
    pend = 1'b1;
    wr_log.delete();
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, pend, 5'd5, 32'h50, 1'b0, 5'd0);
      if (bus.signal_write) wr_log.push_back(bus.address_to_write);
      if (pend && m_q.size() < DEPTH) pend = 1'b0;
    end
    cmp("order_len", 32'(wr_log.size()), 32'd5);
    for (int k = 0; k < 5 && k < wr_log.size(); k++)
      cmp("order_addr", 32'(wr_log[k]), 32'(k + 1));

    // Newest value wins on bypass
    applyStimulus(1'b1, 1'b1, 5'd7, 32'h11, 1'b1, 5'd0);
    applyStimulus(1'b1, 1'b1, 5'd7, 32'h22, 1'b1, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    cmp("byp_hit", 32'(bus.lookup_hit), 32'd1);
    cmp("byp_data", bus.lookup_data, 32'h22);
    for (int c = 0; c < 6; c++) applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7);
    cmp("byp_gone", 32'(bus.lookup_hit), 32'd0);
    cmp("byp_gone_data", bus.lookup_data, 32'd0);

    // Reset mid-drain
    for (int k = 1; k <= 3; k++)
      applyStimulus(1'b1, 1'b1, 5'(k + 8), 32'(k), 1'b1, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd9);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd10);
    cmp("mid_count", 32'(bus.count), 32'd0);
    cmp("mid_write", 32'(bus.signal_write), 32'd0);
    cmp("mid_hit", 32'(bus.lookup_hit), 32'd0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      cmp("mid_nostale", 32'(bus.signal_write), 32'd0);
    end

    // Streaming with no stall wraps the pointers
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0,
                    5'($urandom_range(0, 31)));
      cmp("stream_count_le1", 32'(bus.count <= 5'd1), 32'd1);
    end
    idle(3);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom_range(0, 99) != 0), $urandom_range(0, 1) == 1,
                    5'($urandom_range(0, 7)), $urandom,
                    ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)));
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
